// File: rtl/loader_pkg.sv
// Shared definitions for the instruction RAM loader.
// Holds the FSM state encoding, the default RAM geometry and NOP value,
// and MIPS encoding helpers used to build test images.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum byte).
package loader_pkg;

   localparam int          DEFAULT_AW = 8;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;

   function automatic logic [31:0] make_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] make_itype(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/inst_ram.sv
// Instruction storage: 2^AW x 32 words, one synchronous write port for the
// loader and one asynchronous read port for CPU instruction fetch.
module inst_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];

   // Loader writes land on the clock edge and are readable from the next cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_ram_loader.sv
// Byte-stream loader for the CPU instruction RAM.
// Stream: 16-bit big-endian word count, then big-endian 32-bit words.
// The CPU is held and sees NOP_WORD while a load is in progress.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum byte after the data).
module inst_ram_loader
   import loader_pkg::*;
#(
   parameter int          AW       = DEFAULT_AW,
   parameter logic [31:0] NOP_WORD = NOP
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic [31:0]   Addr,
   output logic [31:0]   INST,
   output logic          cpu_hold,
   output logic          done,
   output logic          overflow,
   output logic [AW:0]   words_loaded,
   output logic          checksum_err
);

   localparam logic [16:0] DEPTH = 17'(1) << AW;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_STATE = ST_CHK;
`else
   localparam state_t END_STATE = ST_DONE;
`endif

   state_t        state;
   logic [15:0]   len;
   logic [1:0]    byte_cnt;
   logic [23:0]   asm_word;
   logic [15:0]   word_idx;
   logic          accept;
   logic          in_range;
   logic          last_word;
   logic          ram_we;
   logic [31:0]   ram_rdata;
   logic          unused_addr;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    xor_acc;
`endif

   assign accept    = in_valid && in_ready;
   assign in_range  = {1'b0, word_idx} < DEPTH;
   assign last_word = (word_idx == (len - 16'd1));
   assign ram_we    = accept && (state == ST_DATA) && (byte_cnt == 2'd3) && in_range;

   assign in_ready  = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_DATA)   || (state == ST_CHK);
   assign cpu_hold  = !((state == ST_IDLE) || (state == ST_DONE));
   assign done      = (state == ST_DONE);

   assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};

   inst_ram #(.AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (word_idx[AW-1:0]),
      .wdata ({asm_word, in_data}),
      .raddr (Addr[AW+1:2]),
      .rdata (ram_rdata)
   );

   assign INST = cpu_hold ? NOP_WORD : ram_rdata;

`ifndef LOADER_CHECKSUM_EN
   assign checksum_err = 1'b0;
`endif

   // Loader FSM: parses the length header, assembles words MSB first and
   // tracks per-load status; out-of-range words are consumed but not written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         len          <= '0;
         byte_cnt     <= '0;
         asm_word     <= '0;
         word_idx     <= '0;
         overflow     <= 1'b0;
         words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc      <= '0;
         checksum_err <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state        <= ST_LEN_HI;
                  byte_cnt     <= '0;
                  word_idx     <= '0;
                  overflow     <= 1'b0;
                  words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                  xor_acc      <= '0;
                  checksum_err <= 1'b0;
`endif
               end
            end
            ST_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= in_data;
                  state     <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  if ({len[15:8], in_data} == 16'd0) begin
                     state <= END_STATE;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_word <= {asm_word[15:0], in_data};
`ifdef LOADER_CHECKSUM_EN
                  xor_acc  <= xor_acc ^ in_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     if (in_range) begin
                        words_loaded <= words_loaded + (AW+1)'(1);
                     end else begin
                        overflow <= 1'b1;
                     end
                     word_idx <= word_idx + 16'd1;
                     if (last_word) begin
                        state <= END_STATE;
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (accept) begin
                  checksum_err <= (in_data != xor_acc);
                  state        <= ST_DONE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
